// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, ALU-op classes and the decoder control bundle.
package rv32_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ULA_ADD   = 2'b00;
    localparam logic [1:0] ULA_FUNCT = 2'b10;

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_wr;
        logic       mux_reg_wr;
        logic       mux_ula;
        logic [1:0] ula_op;
        logic       pc_ula;
        logic       jump;
        logic       branch;
        logic       jalr;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = ctrl_t'(11'd0);

    // Stores also raise mem_rd, so only mem_rd without mem_wr is a load.
    function automatic logic is_load(input ctrl_t c);
        return c.mem_rd & ~c.mem_wr;
    endfunction

endpackage

// File: rtl/id_ex_reg_load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the sources in ID.
module load_use_detect
    import rv32_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid,
    input  ctrl_t             ex_ctrl,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    output logic              load_use
);

    logic ex_load_s;
    logic rd_nz_s;
    logic src_hit_s;

    // Both sources are compared regardless of format; spurious U/J stalls are accepted.
    always_comb begin
        ex_load_s = ex_valid & is_load(ex_ctrl);
        rd_nz_s   = (ex_rd != '0);
        src_hit_s = (ex_rd == id_rs1) | (ex_rd == id_rs2);
        load_use  = ex_load_s & rd_nz_s & src_hit_s & id_valid;
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Optional stall counter output enabled by `define ID_EX_STALL_CNT_EN.
module id_ex_reg
    import rv32_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_val,
    input  logic [XLEN-1:0]   id_rs2_val,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [2:0]        id_funct3,
    input  logic              id_funct7b5,
    input  logic              id_mem_rd,
    input  logic              id_mem_wr,
    input  logic              id_reg_wr,
    input  logic              id_mux_reg_wr,
    input  logic              id_mux_ula,
    input  logic              id_pc_ula,
    input  logic              id_jump,
    input  logic              id_branch,
    input  logic              id_jalr,
    input  logic [1:0]        id_ula_op,
    input  logic              flush_in,
    input  logic              hold_in,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_val,
    output logic [XLEN-1:0]   ex_rs2_val,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [2:0]        ex_funct3,
    output logic              ex_funct7b5,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr,
    output logic              ex_reg_wr,
    output logic              ex_mux_reg_wr,
    output logic              ex_mux_ula,
    output logic              ex_pc_ula,
    output logic              ex_jump,
    output logic              ex_branch,
    output logic              ex_jalr,
    output logic [1:0]        ex_ula_op,
    output logic              stall_out
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    ctrl_t             id_ctrl_s;
    logic              load_use_s;

    logic              valid_q,   valid_d;
    ctrl_t             ctrl_q,    ctrl_d;
    logic [XLEN-1:0]   pc_q,      pc_d;
    logic [XLEN-1:0]   rs1_val_q, rs1_val_d;
    logic [XLEN-1:0]   rs2_val_q, rs2_val_d;
    logic [XLEN-1:0]   imm_q,     imm_d;
    logic [REG_AW-1:0] rs1_q,     rs1_d;
    logic [REG_AW-1:0] rs2_q,     rs2_d;
    logic [REG_AW-1:0] rd_q,      rd_d;
    logic [2:0]        funct3_q,  funct3_d;
    logic              f7b5_q,    f7b5_d;

    always_comb begin
        id_ctrl_s.mem_rd     = id_mem_rd;
        id_ctrl_s.mem_wr     = id_mem_wr;
        id_ctrl_s.reg_wr     = id_reg_wr;
        id_ctrl_s.mux_reg_wr = id_mux_reg_wr;
        id_ctrl_s.mux_ula    = id_mux_ula;
        id_ctrl_s.ula_op     = id_ula_op;
        id_ctrl_s.pc_ula     = id_pc_ula;
        id_ctrl_s.jump       = id_jump;
        id_ctrl_s.branch     = id_branch;
        id_ctrl_s.jalr       = id_jalr;
    end

    load_use_detect #(.REG_AW(REG_AW)) u_lud (
        .ex_valid (valid_q),
        .ex_ctrl  (ctrl_q),
        .ex_rd    (rd_q),
        .id_valid (id_valid),
        .id_rs1   (id_rs1),
        .id_rs2   (id_rs2),
        .load_use (load_use_s)
    );

    // Upstream gives flush precedence, so stall still reflects load_use during a flush.
    always_comb begin
        stall_out = ~rst & (load_use_s | hold_in);
    end

    // Next-state: hold > flush > load-use bubble > empty slot > capture.
    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        pc_d      = pc_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        imm_d     = imm_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        funct3_d  = funct3_q;
        f7b5_d    = f7b5_q;
        if (hold_in) begin
            valid_d = valid_q;
        end else if (flush_in || load_use_s || !id_valid) begin
            valid_d   = 1'b0;
            ctrl_d    = CTRL_NOP;
            pc_d      = '0;
            rs1_val_d = '0;
            rs2_val_d = '0;
            imm_d     = '0;
            rs1_d     = '0;
            rs2_d     = '0;
            rd_d      = '0;
            funct3_d  = 3'b000;
            f7b5_d    = 1'b0;
        end else begin
            valid_d   = 1'b1;
            ctrl_d    = id_ctrl_s;
            pc_d      = id_pc;
            rs1_val_d = id_rs1_val;
            rs2_val_d = id_rs2_val;
            imm_d     = id_imm;
            rs1_d     = id_rs1;
            rs2_d     = id_rs2;
            rd_d      = id_rd;
            funct3_d  = id_funct3;
            f7b5_d    = id_funct7b5;
        end
    end

    // EX-stage state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= CTRL_NOP;
            pc_q      <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            funct3_q  <= 3'b000;
            f7b5_q    <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            pc_q      <= pc_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
            imm_q     <= imm_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            funct3_q  <= funct3_d;
            f7b5_q    <= f7b5_d;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Count only edges where the load-use bubble is actually inserted; saturating.
    always_comb begin
        cnt_d = cnt_q;
        if (hold_in || flush_in) begin
            cnt_d = cnt_q;
        end else if (load_use_s && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;
`endif

    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_rs1_val    = rs1_val_q;
    assign ex_rs2_val    = rs2_val_q;
    assign ex_imm        = imm_q;
    assign ex_rs1        = rs1_q;
    assign ex_rs2        = rs2_q;
    assign ex_rd         = rd_q;
    assign ex_funct3     = funct3_q;
    assign ex_funct7b5   = f7b5_q;
    assign ex_mem_rd     = ctrl_q.mem_rd;
    assign ex_mem_wr     = ctrl_q.mem_wr;
    assign ex_reg_wr     = ctrl_q.reg_wr;
    assign ex_mux_reg_wr = ctrl_q.mux_reg_wr;
    assign ex_mux_ula    = ctrl_q.mux_ula;
    assign ex_pc_ula     = ctrl_q.pc_ula;
    assign ex_jump       = ctrl_q.jump;
    assign ex_branch     = ctrl_q.branch;
    assign ex_jalr       = ctrl_q.jalr;
    assign ex_ula_op     = ctrl_q.ula_op;

endmodule

// File: tb/tb_id_ex_reg.sv
// Table-driven directed bench for id_ex_reg; secondary ID fields are derived from the PC.
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst, id_valid, flush_in, hold_in;
    logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic        id_funct7b5, id_mem_rd, id_mem_wr, id_reg_wr, id_mux_reg_wr, id_mux_ula;
    logic        id_pc_ula, id_jump, id_branch, id_jalr;
    logic [1:0]  id_ula_op;
    logic        ex_valid, stall_out;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_mux_reg_wr, ex_mux_ula;
    logic        ex_pc_ula, ex_jump, ex_branch, ex_jalr;
    logic [1:0]  ex_ula_op;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7b5(id_funct7b5), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
        .id_reg_wr(id_reg_wr), .id_mux_reg_wr(id_mux_reg_wr), .id_mux_ula(id_mux_ula),
        .id_pc_ula(id_pc_ula), .id_jump(id_jump), .id_branch(id_branch), .id_jalr(id_jalr),
        .id_ula_op(id_ula_op), .flush_in(flush_in), .hold_in(hold_in),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_mem_rd(ex_mem_rd),
        .ex_mem_wr(ex_mem_wr), .ex_reg_wr(ex_reg_wr), .ex_mux_reg_wr(ex_mux_reg_wr),
        .ex_mux_ula(ex_mux_ula), .ex_pc_ula(ex_pc_ula), .ex_jump(ex_jump),
        .ex_branch(ex_branch), .ex_jalr(ex_jalr), .ex_ula_op(ex_ula_op),
        .stall_out(stall_out)
`ifdef ID_EX_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    typedef struct {
        logic        rst, vld;
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic        mrd, mwr, rwr, fl, hd;
        logic        e_stall, e_vld;
        logic [31:0] e_pc;
        logic [4:0]  e_rd, e_rs1, e_rs2;
        logic        e_mrd, e_mwr, e_rwr;
    } vec_t;

    function automatic vec_t mk(input int r, v, pc, rd, rs1, rs2, mrd, mwr, rwr, fl, hd,
                                input int st, ev, epc, erd, ers1, ers2, emrd, emwr, erwr);
        vec_t t;
        t.rst = r[0];   t.vld = v[0];     t.pc = 32'(pc);
        t.rd = rd[4:0]; t.rs1 = rs1[4:0]; t.rs2 = rs2[4:0];
        t.mrd = mrd[0]; t.mwr = mwr[0];   t.rwr = rwr[0]; t.fl = fl[0]; t.hd = hd[0];
        t.e_stall = st[0]; t.e_vld = ev[0]; t.e_pc = 32'(epc);
        t.e_rd = erd[4:0]; t.e_rs1 = ers1[4:0]; t.e_rs2 = ers2[4:0];
        t.e_mrd = emrd[0]; t.e_mwr = emwr[0]; t.e_rwr = erwr[0];
        return t;
    endfunction

    // Secondary fields are a fixed function of the PC so a capture is checkable end to end.
    function automatic logic [31:0] f_rs1v(input logic [31:0] p); return p ^ 32'h1111_0000; endfunction
    function automatic logic [31:0] f_rs2v(input logic [31:0] p); return p + 32'h0000_2000; endfunction
    function automatic logic [31:0] f_imm (input logic [31:0] p); return ~p; endfunction

    task automatic drive(input vec_t t);
        rst = t.rst; id_valid = t.vld; id_pc = t.pc;
        id_rd = t.rd; id_rs1 = t.rs1; id_rs2 = t.rs2;
        id_mem_rd = t.mrd; id_mem_wr = t.mwr; id_reg_wr = t.rwr;
        flush_in = t.fl; hold_in = t.hd;
        id_rs1_val = f_rs1v(t.pc); id_rs2_val = f_rs2v(t.pc); id_imm = f_imm(t.pc);
        id_funct3 = t.pc[4:2]; id_funct7b5 = t.pc[2]; id_ula_op = t.pc[3:2];
        id_mux_reg_wr = t.pc[3]; id_mux_ula = t.pc[4]; id_pc_ula = t.pc[5];
        id_jump = t.pc[2] & t.pc[3]; id_branch = t.pc[4] & ~t.pc[2]; id_jalr = t.pc[5] & t.pc[3];
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_ex(input int idx, input vec_t t);
        logic [31:0] p;
        logic        v;
        p = t.e_pc;
        v = t.e_vld;
        chk($sformatf("v%0d ex_valid", idx),   {31'd0, ex_valid},   {31'd0, v});
        chk($sformatf("v%0d ex_pc", idx),      ex_pc,               p);
        chk($sformatf("v%0d ex_rd", idx),      {27'd0, ex_rd},      {27'd0, t.e_rd});
        chk($sformatf("v%0d ex_rs1", idx),     {27'd0, ex_rs1},     {27'd0, t.e_rs1});
        chk($sformatf("v%0d ex_rs2", idx),     {27'd0, ex_rs2},     {27'd0, t.e_rs2});
        chk($sformatf("v%0d ex_mem_rd", idx),  {31'd0, ex_mem_rd},  {31'd0, t.e_mrd});
        chk($sformatf("v%0d ex_mem_wr", idx),  {31'd0, ex_mem_wr},  {31'd0, t.e_mwr});
        chk($sformatf("v%0d ex_reg_wr", idx),  {31'd0, ex_reg_wr},  {31'd0, t.e_rwr});
        chk($sformatf("v%0d ex_rs1_val", idx), ex_rs1_val, v ? f_rs1v(p) : 32'd0);
        chk($sformatf("v%0d ex_rs2_val", idx), ex_rs2_val, v ? f_rs2v(p) : 32'd0);
        chk($sformatf("v%0d ex_imm", idx),     ex_imm,     v ? f_imm(p)  : 32'd0);
        chk($sformatf("v%0d ex_misc", idx),
            {20'd0, ex_funct3, ex_funct7b5, ex_ula_op, ex_mux_reg_wr, ex_mux_ula,
             ex_pc_ula, ex_jump, ex_branch, ex_jalr},
            v ? {20'd0, p[4:2], p[2], p[3:2], p[3], p[4], p[5],
                 p[2] & p[3], p[4] & ~p[2], p[5] & p[3]} : 32'd0);
    endtask

    vec_t vecs[24];

    initial begin
        //             rst vld pc     rd  rs1 rs2 mrd mwr rwr fl hd | st ev epc   erd ers1 ers2 emrd emwr erwr
        vecs[0]  = mk(1, 1, 'h100, 1,  2,  3,  0, 0, 1, 0, 0,  0, 0, 0,     0,  0,  0,  0, 0, 0);
        vecs[1]  = mk(1, 1, 'h100, 1,  2,  3,  0, 0, 1, 0, 1,  0, 0, 0,     0,  0,  0,  0, 0, 0);
        vecs[2]  = mk(0, 1, 'h004, 1,  2,  3,  0, 0, 1, 0, 0,  0, 1, 'h004, 1,  2,  3,  0, 0, 1);
        vecs[3]  = mk(0, 1, 'h008, 5,  1,  0,  1, 0, 1, 0, 0,  0, 1, 'h008, 5,  1,  0,  1, 0, 1);
        vecs[4]  = mk(0, 1, 'h00C, 6,  5,  7,  0, 0, 1, 0, 0,  1, 0, 0,     0,  0,  0,  0, 0, 0);
        vecs[5]  = mk(0, 1, 'h00C, 6,  5,  7,  0, 0, 1, 0, 0,  0, 1, 'h00C, 6,  5,  7,  0, 0, 1);
        vecs[6]  = mk(0, 1, 'h010, 5,  2,  5,  1, 1, 0, 0, 0,  0, 1, 'h010, 5,  2,  5,  1, 1, 0);
        vecs[7]  = mk(0, 1, 'h014, 8,  5,  5,  0, 0, 1, 0, 0,  0, 1, 'h014, 8,  5,  5,  0, 0, 1);
        vecs[8]  = mk(0, 1, 'h018, 0,  1,  2,  1, 0, 1, 0, 0,  0, 1, 'h018, 0,  1,  2,  1, 0, 1);
        vecs[9]  = mk(0, 1, 'h01C, 9,  3,  0,  0, 0, 1, 0, 0,  0, 1, 'h01C, 9,  3,  0,  0, 0, 1);
        vecs[10] = mk(0, 1, 'h020, 10, 1,  2,  1, 0, 1, 0, 0,  0, 1, 'h020, 10, 1,  2,  1, 0, 1);
        vecs[11] = mk(0, 1, 'h024, 11, 10, 0,  0, 0, 1, 1, 0,  1, 0, 0,     0,  0,  0,  0, 0, 0);
        vecs[12] = mk(0, 1, 'h028, 12, 10, 0,  0, 0, 1, 0, 0,  0, 1, 'h028, 12, 10, 0,  0, 0, 1);
        vecs[13] = mk(0, 1, 'h02C, 13, 1,  2,  0, 0, 1, 0, 1,  1, 1, 'h028, 12, 10, 0,  0, 0, 1);
        vecs[14] = mk(0, 1, 'h030, 13, 1,  2,  0, 0, 1, 0, 1,  1, 1, 'h028, 12, 10, 0,  0, 0, 1);
        vecs[15] = mk(0, 1, 'h034, 13, 1,  2,  0, 0, 1, 1, 1,  1, 1, 'h028, 12, 10, 0,  0, 0, 1);
        vecs[16] = mk(0, 1, 'h038, 14, 1,  2,  0, 0, 1, 0, 0,  0, 1, 'h038, 14, 1,  2,  0, 0, 1);
        vecs[17] = mk(0, 0, 'h03C, 15, 1,  2,  0, 0, 1, 0, 0,  0, 0, 0,     0,  0,  0,  0, 0, 0);
        vecs[18] = mk(0, 1, 'h040, 3,  1,  2,  1, 0, 1, 0, 0,  0, 1, 'h040, 3,  1,  2,  1, 0, 1);
        vecs[19] = mk(0, 1, 'h044, 4,  3,  0,  1, 0, 1, 0, 0,  1, 0, 0,     0,  0,  0,  0, 0, 0);
        vecs[20] = mk(0, 1, 'h044, 4,  3,  0,  1, 0, 1, 0, 0,  0, 1, 'h044, 4,  3,  0,  1, 0, 1);
        vecs[21] = mk(0, 1, 'h048, 15, 3,  9,  0, 0, 1, 0, 0,  0, 1, 'h048, 15, 3,  9,  0, 0, 1);
        vecs[22] = mk(0, 1, 'h04C, 7,  1,  2,  1, 0, 1, 0, 0,  0, 1, 'h04C, 7,  1,  2,  1, 0, 1);
        vecs[23] = mk(0, 0, 'h050, 8,  7,  7,  0, 0, 1, 0, 0,  0, 0, 0,     0,  0,  0,  0, 0, 0);

        drive(vecs[0]);
        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d stall_out", i), {31'd0, stall_out}, {31'd0, vecs[i].e_stall});
            @(posedge clk);
            #1;
            chk_ex(i, vecs[i]);
            @(negedge clk);
        end
`ifdef ID_EX_STALL_CNT_EN
        chk("stall_cnt after table", stall_cnt, 32'd2);
`endif

        // Reset mid-stream with hold asserted: stall must stay low and EX must clear.
        drive(mk(1, 1, 'h060, 2, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("midrst stall_out", {31'd0, stall_out}, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("midrst ex_pc", ex_pc, 32'd0);
`ifdef ID_EX_STALL_CNT_EN
        chk("midrst stall_cnt", stall_cnt, 32'd0);
`endif
        @(negedge clk);
        drive(mk(0, 1, 'h064, 2, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("post-rst ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("post-rst ex_pc", ex_pc, 32'h0000_0064);
        chk("post-rst ex_rs1_val", ex_rs1_val, f_rs1v(32'h0000_0064));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Pipeline register between Decode (ID) and Execute (EX) of the RV32I 5-stage core.
- Latches the ID-stage control bundle produced by the opcode decoder, plus the operand values and fields decoded alongside it.
- Detects load-use hazards and inserts a single bubble, raising a stall toward PC and IF/ID.
- Kills the ID instruction on a taken-branch/jump flush and holds its contents on an external hold.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register-address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rs1_val  in  XLEN  register-file read A
id_rs2_val  in  XLEN  register-file read B
id_imm  in  XLEN  sign-extended immediate
id_rs1  in  REG_AW  source 1 address
id_rs2  in  REG_AW  source 2 address
id_rd  in  REG_AW  destination address
id_funct3  in  3  funct3
id_funct7b5  in  1  instr[30]
id_mem_rd, id_mem_wr, id_reg_wr, id_mux_reg_wr, id_mux_ula, id_pc_ula, id_jump, id_branch, id_jalr  in  1 each  decoder controls
id_ula_op  in  2  ALU op class
flush_in  in  1  taken branch/jump resolved in EX; kill ID
hold_in  in  1  downstream not ready; freeze EX
ex_valid  out  1  EX holds a real instruction
ex_*  out  same widths  registered copy of every id_* data/control input above (ex_pc … ex_ula_op)
stall_out  out  1  freeze PC and IF/ID this cycle

Behaviour:
- Reset: every ex_* output, including ex_valid, goes to 0 on the rising edge with rst=1.
- stall_out is 0 while rst=1.
- Load detection: a load in EX is ex_valid & ex_mem_rd & ~ex_mem_wr. Stores also assert mem_rd, so mem_wr must be excluded.
- load_use (combinational) = load in EX & ex_rd != 0 & (ex_rd == id_rs1 | ex_rd == id_rs2) & id_valid.
  - The comparison is deliberately conservative: both sources are compared regardless of format (U/J-type may stall spuriously; accepted).
- stall_out = load_use | hold_in (combinational, same cycle).
- Per-edge update priority:
  1. rst: clear all.
  2. hold_in: all ex_* retain their values. A pending flush is not lost; the flush source keeps flush_in asserted until it is taken.
  3. flush_in: bubble.
  4. load_use: bubble. The next cycle, EX holds no load, so load_use drops and the stalled ID instruction enters. Exactly one bubble per hazard.
  5. id_valid=0: bubble.
  6. Otherwise: capture all id_* fields; ex_valid=1.
- Bubble means:
  - ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump and ex_jalr = 0.
  - All remaining ex_* fields = 0. This makes the bubble deterministic and side-effect free.
- Latency: 1 cycle ID→EX; no combinational path from id_* to ex_*.
- Edge cases:
  - flush_in and load_use together: flush wins, producing a single bubble. stall_out still follows load_use that cycle; upstream gives flush precedence.
  - ex_rd = x0 never stalls.
  - Back-to-back loads with a dependent third instruction stall only against the load currently in EX.
  - Deasserting rst mid-stream: the first captured instruction is whatever ID presents on the next edge.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (32 bits), reset to 0.
  - Increments on each edge where a load-use bubble is inserted (priority 4 taken).
  - Saturates at 0xFFFFFFFF; hold and flush cycles are not counted.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package rv32_pkg:
  - Opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR).
  - ula_op encodings (ULA_ADD=2'b00, ULA_FUNCT=2'b10).
  - A packed control-bundle typedef ctrl_t {mem_rd, mem_wr, reg_wr, mux_reg_wr, mux_ula, ula_op, pc_ula, jump, branch, jalr}.
  - The bubble constant CTRL_NOP = all zeros.
- One natural sub-module: load_use_detect, holding the pure combinational hazard compare. Sequential state remains in id_ex_reg.

Test Plan:
1. Reset: assert rst 2 cycles with id_valid=1 → all ex_* = 0 and stall_out = 0; the first edge after release captures id_pc=0x0000_0004.
2. Load-use: lw x5 (ex_rd=5, mem_rd=1, mem_wr=0) in EX, then add x6,x5,x7 in ID → stall_out=1 for 1 cycle and a bubble; next edge ex_pc = add's PC, ex_rs1=5. The counter (if enabled) = 1.
3. Store not a load: sw in EX (mem_rd=1, mem_wr=1, ex_rd field=5) with ID rs1=5 → stall_out=0, no bubble.
4. x0 destination: load with rd=0 in EX, ID rs2=0 → no stall.
5. Flush plus load_use in the same cycle → a single bubble (ex_valid=0, ex_reg_wr=0), no duplicate bubble on the next edge.
6. Hold: hold_in=1 for 3 cycles with ID changing → ex_* unchanged and stall_out=1 throughout; the first edge after release captures current ID.
